// File: rtl/decode_hazard_ctrl.sv
// ID-stage hazard sequencer: load-use interlock, CSR serialization drain and
// post-redirect flush window, plus a free-running stall-cycle counter.
//
// state     | meaning
// RUN       | normal issue; load-use and CSR entry decided combinationally
// CSR_DRAIN | CSR held in ID while older instructions drain (cnt bubbles left)
// FLUSH     | wrong-path window after an EX redirect (cnt cycles left)
module decode_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int CSR_LAT      = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_is_csr,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_redirect,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic [CNT_W-1:0]      stall_count
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    CSR_DRAIN = 2'd1,
    FLUSH     = 2'd2
  } state_t;

  // Reload values for cnt; the first bubble/flush cycle is spent in RUN.
  localparam logic [2:0] CSR_INIT = (CSR_LAT > 1) ? 3'(CSR_LAT - 2) : 3'd0;
  localparam logic [2:0] FL_INIT  = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;
  localparam bit         CSR_MULTI = (CSR_LAT > 1);
  localparam bit         FL_MULTI  = (FLUSH_CYCLES > 1);

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic       csr_armed, csr_armed_nx;
  logic       lu;
  logic       stall, fl_id, fl_ex;

  assign lu = id_valid & ex_valid & ex_is_load & (ex_rd != '0) &
              ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= 3'd0;
      csr_armed <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      csr_armed <= csr_armed_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    csr_armed_nx = csr_armed;
    stall        = 1'b0;
    fl_id        = 1'b0;
    fl_ex        = 1'b0;
    unique case (state)
      RUN, CSR_DRAIN: begin
        if (ex_redirect) begin
          fl_id        = 1'b1;
          fl_ex        = 1'b1;
          csr_armed_nx = 1'b0;
          if (FL_MULTI) begin
            state_nx = FLUSH;
            cnt_nx   = FL_INIT;
          end else begin
            state_nx = RUN;
          end
        end else if (state == CSR_DRAIN) begin
          stall = 1'b1;
          fl_ex = 1'b1;
          if (cnt == 3'd0) begin
            csr_armed_nx = 1'b1;
            state_nx     = RUN;
          end else begin
            cnt_nx = cnt - 3'd1;
          end
        end else if (id_valid & id_is_csr & ~csr_armed) begin
          stall = 1'b1;
          fl_ex = 1'b1;
          if (CSR_MULTI) begin
            state_nx = CSR_DRAIN;
            cnt_nx   = CSR_INIT;
          end else begin
            csr_armed_nx = 1'b1;
          end
        end else if (lu) begin
          stall = 1'b1;
          fl_ex = 1'b1;
        end else if (id_valid & csr_armed) begin
          // armed CSR leaves ID this cycle
          csr_armed_nx = 1'b0;
        end
      end
      FLUSH: begin
        fl_id = 1'b1;
        if (ex_redirect) begin
          fl_ex  = 1'b1;
          cnt_nx = FL_INIT;
        end else if (cnt == 3'd0) begin
          state_nx = RUN;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = 3'd0;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held, whatever the inputs show.
  assign stall_if = stall & ~rst;
  assign stall_id = stall & ~rst;
  assign flush_id = fl_id & ~rst;
  assign flush_ex = fl_ex & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall_id) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Scoreboard bench for decode_hazard_ctrl: directed scenarios then random traffic,
// with expectations from a cycles-remaining reference model.
module tb_decode_hazard_ctrl;
  localparam int RW = 5;
  localparam int CSR_LAT = 4;
  localparam int FLUSH_CYCLES = 3;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 0, id_uses_rs1 = 0, id_uses_rs2 = 0, id_is_csr = 0;
  logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic ex_valid = 0, ex_is_load = 0, ex_redirect = 0;
  logic stall_if, stall_id, flush_id, flush_ex;
  logic [CNT_W-1:0] stall_count;

  always #5 clk = ~clk;

  decode_hazard_ctrl #(.REG_ADDR_W(RW), .CSR_LAT(CSR_LAT), .FLUSH_CYCLES(FLUSH_CYCLES),
                       .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_csr(id_is_csr),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
    .stall_count(stall_count));

  typedef struct {
    logic sif, sid, fid, fex;
    logic [CNT_W-1:0] cnt;
    int step;
  } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0, step_no = 0;

  // reference model: cycles remaining in each window
  int flush_rem = 0, drain_rem = 0;
  bit armed = 0;
  longint stall_total = 0;

  task automatic drive(input bit r, input bit v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                       input bit u1, input bit u2, input bit csr, input bit exv,
                       input logic [RW-1:0] rd, input bit ld, input bit redir);
    exp_t e;
    bit lu;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_is_csr = csr; ex_valid = exv; ex_rd = rd; ex_is_load = ld; ex_redirect = redir;
    step_no++;
    e.sif = 0; e.sid = 0; e.fid = 0; e.fex = 0; e.step = step_no;
    if (r) begin
      flush_rem = 0; drain_rem = 0; armed = 0; stall_total = 0;
      e.cnt = '0;
    end else begin
      e.cnt = CNT_W'(stall_total);
      lu = v && exv && ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      if (flush_rem > 0) begin
        e.fid = 1;
        if (redir) begin e.fex = 1; flush_rem = FLUSH_CYCLES - 1; end
        else flush_rem--;
      end else if (redir) begin
        e.fid = 1; e.fex = 1; drain_rem = 0; armed = 0; flush_rem = FLUSH_CYCLES - 1;
      end else if (drain_rem > 0) begin
        e.sif = 1; e.sid = 1; e.fex = 1;
        drain_rem--;
        if (drain_rem == 0) armed = 1;
      end else if (v && csr && !armed) begin
        e.sif = 1; e.sid = 1; e.fex = 1;
        drain_rem = CSR_LAT - 1;
        if (drain_rem == 0) armed = 1;
      end else if (lu) begin
        e.sif = 1; e.sid = 1; e.fex = 1;
      end else if (v && armed) begin
        armed = 0;
      end
      if (e.sid) stall_total++;
    end
    q.push_back(e);
  endtask

  task automatic idle(input bit r);
    drive(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int step, input logic [CNT_W-1:0] act,
                     input logic [CNT_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, step, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_if", e.step, CNT_W'(stall_if), CNT_W'(e.sif));
        chk("stall_id", e.step, CNT_W'(stall_id), CNT_W'(e.sid));
        chk("flush_id", e.step, CNT_W'(flush_id), CNT_W'(e.fid));
        chk("flush_ex", e.step, CNT_W'(flush_ex), CNT_W'(e.fex));
        chk("stall_count", e.step, stall_count, e.cnt);
      end
    end
  end

  initial begin : stim
    int waited;
    // reset held with noisy inputs: outputs must stay quiet
    drive(1, 1, 5, 5, 1, 1, 1, 1, 5, 1, 1);
    drive(1, 1, 5, 0, 1, 0, 0, 1, 5, 1, 0);
    idle(0);
    // load-use on rs1, then the load has left EX
    drive(0, 1, 5, 1, 1, 1, 0, 1, 5, 1, 0);
    drive(0, 1, 5, 1, 1, 1, 0, 1, 9, 0, 0);
    // x0 destination never hazards
    drive(0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0);
    // rs2 hazard, rs2 unused, non-load producer
    drive(0, 1, 3, 7, 1, 1, 0, 1, 7, 1, 0);
    drive(0, 1, 3, 7, 1, 0, 0, 1, 7, 1, 0);
    drive(0, 1, 3, 7, 1, 1, 0, 1, 7, 0, 0);
    // CSR held in ID: CSR_LAT bubbles then issues
    repeat (CSR_LAT + 1) drive(0, 1, 1, 2, 1, 1, 1, 0, 0, 0, 0);
    idle(0);
    // armed CSR still honours load-use before issuing
    repeat (CSR_LAT) drive(0, 1, 6, 2, 1, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 6, 2, 1, 1, 1, 1, 6, 1, 0);
    drive(0, 1, 6, 2, 1, 1, 1, 0, 0, 0, 0);
    idle(0);
    // redirect window, then extended by a second redirect on cycle 2
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    repeat (3) idle(0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    repeat (4) idle(0);
    // redirect on second drain cycle aborts CSR; fresh CSR drains fully afterwards
    drive(0, 1, 1, 2, 1, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 2, 1, 1, 1, 1, 0, 0, 1);
    repeat (FLUSH_CYCLES - 1) drive(0, 1, 1, 2, 1, 1, 1, 1, 1, 1, 0);
    repeat (CSR_LAT + 1) drive(0, 1, 1, 2, 1, 1, 1, 0, 0, 0, 0);
    // async reset mid-flush, then load-use behaves as from cold
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    idle(1);
    drive(0, 1, 5, 1, 1, 1, 0, 1, 5, 1, 0);
    drive(0, 1, 5, 1, 1, 1, 0, 1, 9, 0, 0);
    // random traffic with small register range to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 249) == 0),
            $urandom_range(0, 3) != 0,
            RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 3) != 0,
            RW'($urandom_range(0, 3)),
            $urandom_range(0, 1),
            $urandom_range(0, 15) == 0);
    end
    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_queue actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
